aes_inv_key_sched: RTL

//  Iterative AES-128 key scheduler for the decrypt datapath. It accepts the cipher key,

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_rcon.sv | 21 ++
 rtl/aes_sbox.sv | 9 +
 rtl/aes_sub_word.sv | 14 +
 rtl/aes_inv_key_sched.sv | 122 ++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, FSM encoding and byte/word helpers.
// The S-box is computed as GF(2^8) inversion followed by the affine map.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [KEY_W-1:0]  key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Inverse as a^254 = a^240 * a^12 * a^2; zero maps to zero naturally.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] x12;
    logic [7:0] x15;
    logic [7:0] x240;
    logic [7:0] inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_rcon.sv
// AES round constant lookup; valid indices are 1..10.
module aes_rcon (
  input  logic [3:0] idx,
  output logic [7:0] rcon
);
  always_comb begin
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end
endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box.
import aes_pkg::*;

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox(a);
endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-boxes over one 32-bit word.
import aes_pkg::*;

module aes_sub_word (
  input  word_t a,
  output word_t y
);
  for (genvar i = 0; i < 4; i++) begin : g_byte
    aes_sbox u_sbox (
      .a(a[8*i +: 8]),
      .y(y[8*i +: 8])
    );
  end
endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 key scheduler: expands forward to round 10, then streams
// round keys 10..0 by undoing one expansion step per handshake.
import aes_pkg::*;

module aes_inv_key_sched #(
  parameter int CACHE_LAST_KEY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             replay,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round,
  output logic             rk_last,
  output logic             cached
);

  localparam logic [3:0] LAST_RND = 4'(AES_NR);

  state_t     state;
  key_t       key_reg;
  key_t       shadow;
  logic [3:0] rnd;

  word_t      w0, w1, w2, w3;
  word_t      p1, p2, p3, p0;
  word_t      n0, n1, n2, n3;
  word_t      sw_in, sw_out, rc_word;
  logic [3:0] rc_idx;
  logic [7:0] rc;

  assign {w0, w1, w2, w3} = key_reg;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // One S-box word and one rcon lookup are shared by the forward and inverse steps.
  assign sw_in   = rot_word((state == EXPAND) ? w3 : p3);
  assign rc_idx  = (state == EXPAND) ? (rnd + 4'd1) : rnd;
  assign rc_word = {rc, 24'h0};

  aes_rcon u_rcon (
    .idx (rc_idx),
    .rcon(rc)
  );

  aes_sub_word u_sub_word (
    .a(sw_in),
    .y(sw_out)
  );

  assign n0 = w0 ^ sw_out ^ rc_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign p0 = w0 ^ sw_out ^ rc_word;

  assign rk_data  = key_reg;
  assign rk_round = rnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      shadow    <= '0;
      rnd       <= '0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      cached    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_reg   <= key_in;
            rnd       <= '0;
            key_ready <= 1'b0;
            state     <= EXPAND;
          end else if (replay && cached) begin
            key_reg   <= shadow;
            rnd       <= LAST_RND;
            key_ready <= 1'b0;
            rk_valid  <= 1'b1;
            state     <= STREAM;
          end
        end
        EXPAND: begin
          key_reg <= {n0, n1, n2, n3};
          rnd     <= rnd + 4'd1;
          if (rnd + 4'd1 == LAST_RND) begin
            rk_valid <= 1'b1;
            state    <= STREAM;
            if (CACHE_LAST_KEY != 0) begin
              shadow <= {n0, n1, n2, n3};
              cached <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (rk_valid && rk_ready) begin
            if (rnd == 4'd0) begin
              rk_valid  <= 1'b0;
              rk_last   <= 1'b0;
              key_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              key_reg <= {p0, p1, p2, p3};
              rnd     <= rnd - 4'd1;
              rk_last <= (rnd == 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
